// File: rtl/mandelbrot_counter_pkg.sv
// mandelbrot_counter_pkg: mode selectors and legal parameter ranges for the counter bank
package mandelbrot_counter_pkg;
    localparam int MODE_WRAP      = 0;
    localparam int MODE_SATURATE  = 1;
    localparam int WIDTH_MIN      = 2;
    localparam int WIDTH_MAX      = 32;
    localparam int CHANNELS_MIN   = 1;
    localparam int CHANNELS_MAX   = 16;
    localparam int STEP_WIDTH_MIN = 1;
endpackage

// File: rtl/mandelbrot_counter_lane.sv
// mandelbrot_counter_lane: one up/down counter channel with load, wrap or clamp, flags and overflow pulse
module mandelbrot_counter_lane
    import mandelbrot_counter_pkg::*;
#(
    parameter int                 C_WIDTH      = 8,
    parameter int                 C_STEP_WIDTH = 4,
    parameter int                 C_SATURATE   = MODE_WRAP,
    parameter logic [C_WIDTH-1:0] C_INIT       = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clken,
    input  logic                    load,
    input  logic                    incr,
    input  logic                    decr,
    input  logic [C_STEP_WIDTH-1:0] step,
    input  logic [C_WIDTH-1:0]      load_value,
    output logic [C_WIDTH-1:0]      count,
    output logic                    is_zero,
    output logic                    is_max,
    output logic                    ovf,
    output logic                    zero_d
);
    localparam bit SAT = C_SATURATE == MODE_SATURATE;
    logic [C_WIDTH-1:0] count_q = C_INIT;
    logic               zero_q  = C_INIT == '0;
    logic               max_q   = &C_INIT;
    logic               ovf_q   = 1'b0;
    logic [C_WIDTH:0]   st, sum, diff;
    logic [C_WIDTH-1:0] move, cnt_d;
    logic               up, dn, carry, borrow, ovf_d;
    always_comb begin
        st     = (C_WIDTH+1)'(step);
        sum    = {1'b0, count_q} + st;
        diff   = {1'b0, count_q} - st;
        up     = incr & ~decr;
        dn     = decr & ~incr;
        carry  = up & sum[C_WIDTH];
        borrow = dn & diff[C_WIDTH];
        move   = up ? ((carry && SAT) ? {C_WIDTH{1'b1}} : sum[C_WIDTH-1:0])
               : dn ? ((borrow && SAT) ? {C_WIDTH{1'b0}} : diff[C_WIDTH-1:0])
               : count_q;
        cnt_d  = rst ? C_INIT : !clken ? count_q : load ? load_value : move;
        ovf_d  = !rst && clken && !load && (carry || borrow);
        zero_d = cnt_d == '0;
    end
    // flags derive from the value being written, so they never lag the count
    always_ff @(posedge clk) begin
        count_q <= cnt_d;
        zero_q  <= zero_d;
        max_q   <= &cnt_d;
        ovf_q   <= ovf_d;
    end
    assign count   = count_q;
    assign is_zero = zero_q;
    assign is_max  = max_q;
    assign ovf     = ovf_q;
endmodule

// File: rtl/mandelbrot_counter_bank.sv
// mandelbrot_counter_bank: bank of independent load/step counters with zero, max and overflow flags
module mandelbrot_counter_bank
    import mandelbrot_counter_pkg::*;
#(
    parameter int                 C_WIDTH      = 8,
    parameter int                 C_CHANNELS   = 4,
    parameter int                 C_STEP_WIDTH = 4,
    parameter int                 C_SATURATE   = MODE_WRAP,
    parameter logic [C_WIDTH-1:0] C_INIT       = '0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               clken,
    input  logic [C_CHANNELS-1:0]              load,
    input  logic [C_CHANNELS-1:0]              incr,
    input  logic [C_CHANNELS-1:0]              decr,
    input  logic [C_CHANNELS*C_STEP_WIDTH-1:0] step,
    input  logic [C_CHANNELS*C_WIDTH-1:0]      load_value,
    output logic [C_CHANNELS*C_WIDTH-1:0]      count,
    output logic [C_CHANNELS-1:0]              is_zero,
    output logic [C_CHANNELS-1:0]              is_max,
    output logic [C_CHANNELS-1:0]              ovf,
    output logic                               any_zero
);
    if (C_WIDTH < WIDTH_MIN || C_WIDTH > WIDTH_MAX || C_CHANNELS < CHANNELS_MIN ||
        C_CHANNELS > CHANNELS_MAX || C_STEP_WIDTH < STEP_WIDTH_MIN || C_STEP_WIDTH > C_WIDTH ||
        (C_SATURATE != MODE_WRAP && C_SATURATE != MODE_SATURATE)) begin : g_bad_params
        $error("mandelbrot_counter_bank: parameter out of range");
    end
    logic [C_CHANNELS-1:0] zero_d;
    logic                  any_zero_q = C_INIT == '0;
    for (genvar i = 0; i < C_CHANNELS; i++) begin : g_lane
        mandelbrot_counter_lane #(
            .C_WIDTH(C_WIDTH), .C_STEP_WIDTH(C_STEP_WIDTH), .C_SATURATE(C_SATURATE), .C_INIT(C_INIT)
        ) u_lane (
            .clk(clk), .rst(rst), .clken(clken),
            .load(load[i]), .incr(incr[i]), .decr(decr[i]),
            .step(step[i*C_STEP_WIDTH +: C_STEP_WIDTH]),
            .load_value(load_value[i*C_WIDTH +: C_WIDTH]),
            .count(count[i*C_WIDTH +: C_WIDTH]),
            .is_zero(is_zero[i]), .is_max(is_max[i]), .ovf(ovf[i]), .zero_d(zero_d[i])
        );
    end
    // built from the lanes' next-zero terms so it lands in the same cycle as is_zero
    always_ff @(posedge clk) any_zero_q <= |zero_d;
    assign any_zero = any_zero_q;
endmodule

// File: tb/tb_mandelbrot_counter_bank.sv
// tb_mandelbrot_counter_bank: random and directed checks of wrap and saturate banks against an arithmetic model
module tb_mandelbrot_counter_bank;
    logic        clk = 1'b0;
    logic        rst, clken;
    logic [3:0]  load, incr, decr;
    logic [15:0] step;
    logic [31:0] load_value;
    logic [31:0] count_w, count_s;
    logic [3:0]  is_zero_w, is_zero_s, is_max_w, is_max_s, ovf_w, ovf_s;
    logic        any_zero_w, any_zero_s;
    int          n_checks = 0, n_errors = 0;
    int          m_cnt[2][4];
    bit          m_ovf[2][4];

    always #5 clk = ~clk;

    mandelbrot_counter_bank #(.C_SATURATE(0)) dut_w (
        .clk(clk), .rst(rst), .clken(clken), .load(load), .incr(incr), .decr(decr),
        .step(step), .load_value(load_value), .count(count_w), .is_zero(is_zero_w),
        .is_max(is_max_w), .ovf(ovf_w), .any_zero(any_zero_w)
    );
    mandelbrot_counter_bank #(.C_SATURATE(1)) dut_s (
        .clk(clk), .rst(rst), .clken(clken), .load(load), .incr(incr), .decr(decr),
        .step(step), .load_value(load_value), .count(count_s), .is_zero(is_zero_s),
        .is_max(is_max_s), .ovf(ovf_s), .any_zero(any_zero_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // mode 0 wraps modulo 256, mode 1 clamps; ovf means the true result left 0..255
    task automatic model_update();
        for (int m = 0; m < 2; m++)
            for (int ch = 0; ch < 4; ch++) begin
                int v;
                m_ovf[m][ch] = 1'b0;
                if (rst) m_cnt[m][ch] = 0;
                else if (!clken) ;
                else if (load[ch]) m_cnt[m][ch] = int'(load_value[ch*8 +: 8]);
                else if (incr[ch] != decr[ch]) begin
                    v = incr[ch] ? m_cnt[m][ch] + int'(step[ch*4 +: 4]) : m_cnt[m][ch] - int'(step[ch*4 +: 4]);
                    if (v > 255) begin m_ovf[m][ch] = 1'b1; v = m ? 255 : v - 256; end
                    if (v < 0)   begin m_ovf[m][ch] = 1'b1; v = m ? 0 : v + 256; end
                    m_cnt[m][ch] = v;
                end
            end
    endtask

    task automatic compare_all(input string tag);
        logic [31:0] ec[2];
        logic [3:0]  ez[2], em[2], eo[2];
        for (int m = 0; m < 2; m++)
            for (int ch = 0; ch < 4; ch++) begin
                ec[m][ch*8 +: 8] = 8'(m_cnt[m][ch]);
                ez[m][ch] = m_cnt[m][ch] == 0;
                em[m][ch] = m_cnt[m][ch] == 255;
                eo[m][ch] = m_ovf[m][ch];
            end
        check({tag, ":w.count"}, count_w, ec[0]);
        check({tag, ":w.zero"}, 32'(is_zero_w), 32'(ez[0]));
        check({tag, ":w.max"}, 32'(is_max_w), 32'(em[0]));
        check({tag, ":w.ovf"}, 32'(ovf_w), 32'(eo[0]));
        check({tag, ":w.any"}, 32'(any_zero_w), 32'(|ez[0]));
        check({tag, ":s.count"}, count_s, ec[1]);
        check({tag, ":s.zero"}, 32'(is_zero_s), 32'(ez[1]));
        check({tag, ":s.max"}, 32'(is_max_s), 32'(em[1]));
        check({tag, ":s.ovf"}, 32'(ovf_s), 32'(eo[1]));
        check({tag, ":s.any"}, 32'(any_zero_s), 32'(|ez[1]));
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_update();
        #1;
        compare_all(tag);
    endtask

    task automatic idle();
        rst = 1'b0; clken = 1'b1; load = '0; incr = '0; decr = '0; step = '0; load_value = '0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        cycle("reset");
        check("r034.zero", 32'(is_zero_w), 32'hF);
        check("r034.any", 32'(any_zero_w), 32'd1);
        idle();
        load = 4'b0001; load_value[7:0] = 8'd250;
        cycle("r035.load");
        idle(); incr = 4'b0001; step[3:0] = 4'd10;
        cycle("r035.incr");
        check("r035.cnt", 32'(count_w[7:0]), 32'd4);
        check("r035.ovf", 32'(ovf_w[0]), 32'd1);
        idle();
        cycle("r035.hold");
        check("r035.ovf_hold", 32'(ovf_w[0]), 32'd0);
        load = 4'b0010; load_value[15:8] = 8'd3;
        cycle("r036.load");
        idle(); decr = 4'b0010; step[7:4] = 4'd5;
        cycle("r036.decr1");
        check("r036.cnt", 32'(count_s[15:8]), 32'd0);
        check("r036.ovf1", 32'(ovf_s[1]), 32'd1);
        cycle("r036.decr2");
        check("r036.ovf2", 32'(ovf_s[1]), 32'd1);
        idle(); load = 4'b0100; load_value[23:16] = 8'd250;
        cycle("r037.load");
        idle(); incr = 4'b0100; step[11:8] = 4'd5;
        cycle("r037.incr");
        check("r037.cnt", 32'(count_s[23:16]), 32'd255);
        check("r037.max", 32'(is_max_s[2]), 32'd1);
        check("r037.ovf", 32'(ovf_s[2]), 32'd0);
        idle(); load = 4'b1000; load_value[31:24] = 8'd7;
        cycle("r038.pre");
        idle(); load = 4'b1000; incr = 4'b1000; step[15:12] = 4'd3;
        clken = 1'b0;
        cycle("r038.gated");
        check("r038.gated_cnt", 32'(count_w[31:24]), 32'd7);
        clken = 1'b1;
        cycle("r038.load");
        check("r038.cnt", 32'(count_w[31:24]), 32'd0);
        check("r038.ovf", 32'(ovf_w), 32'd0);
        idle(); incr = 4'hF; step = 16'h1111;
        repeat (3) cycle("r039.run");
        rst = 1'b1;
        cycle("r039.rst");
        check("r039.cnt", count_s, 32'd0);
        for (int n = 0; n < 400; n++) begin
            rst        = $urandom_range(0, 49) == 0;
            clken      = $urandom_range(0, 7) != 0;
            load       = 4'($urandom) & 4'($urandom) & 4'($urandom);
            incr       = 4'($urandom);
            decr       = 4'($urandom);
            step       = 16'($urandom);
            load_value = $urandom;
            cycle("rand");
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
